pll_lock_reset_seq: RTL and testbench

//  Consumer side of the PLL lock interface. Runs on the free-running 25 MHz board clock, not the PLL output.

---
 rtl/pll_lock_reset_seq.sv | 143 ++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// PLL lock consumer: synchronises and filters `locked`, sequences the system reset, and reports timeouts and lock losses.
// Optional feature macro: LOCK_LOSS_CNT_EN enables the saturating loss_cnt counter (tied to 0 otherwise).
module pll_lock_reset_seq #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LOCK_FILTER = 1024,
   parameter int unsigned RST_HOLD    = 16,
   parameter int unsigned TIMEOUT     = 1048576,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             locked,
   output logic             sys_rst,
   output logic             ready,
   output logic             lost_pulse,
   output logic             lock_timeout,
   output logic [CNT_W-1:0] loss_cnt
);

   localparam int unsigned FCNT_W = $clog2(LOCK_FILTER + 1);
   localparam int unsigned HCNT_W = $clog2(RST_HOLD + 1);
   localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
   logic [HCNT_W-1:0]      hcnt_q, hcnt_d;
   logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
   logic                   sys_rst_q, sys_rst_d;
   logic                   ready_q, ready_d;
   logic                   lost_pulse_q, lost_pulse_d;
   logic                   lock_timeout_q, lock_timeout_d;
   logic                   locked_s;

   assign sync_d   = {sync_q[SYNC_STAGES-2:0], locked};
   assign locked_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= WAIT_LOCK;
         sync_q         <= '0;
         fcnt_q         <= '0;
         hcnt_q         <= '0;
         tcnt_q         <= '0;
         sys_rst_q      <= 1'b1;
         ready_q        <= 1'b0;
         lost_pulse_q   <= 1'b0;
         lock_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         sync_q         <= sync_d;
         fcnt_q         <= fcnt_d;
         hcnt_q         <= hcnt_d;
         tcnt_q         <= tcnt_d;
         sys_rst_q      <= sys_rst_d;
         ready_q        <= ready_d;
         lost_pulse_q   <= lost_pulse_d;
         lock_timeout_q <= lock_timeout_d;
      end
   end

   // Next state, counters and registered outputs; a loss always beats a pending RUN entry.
   always_comb begin
      state_d        = state_q;
      fcnt_d         = fcnt_q;
      hcnt_d         = hcnt_q;
      tcnt_d         = tcnt_q;
      lock_timeout_d = lock_timeout_q;
      lost_pulse_d   = 1'b0;

      case (state_q)
         WAIT_LOCK: begin
            if (tcnt_q != TCNT_W'(TIMEOUT))
               tcnt_d = tcnt_q + TCNT_W'(1);
            if (tcnt_d == TCNT_W'(TIMEOUT))
               lock_timeout_d = 1'b1;
            if (locked_s) begin
               fcnt_d = fcnt_q + FCNT_W'(1);
               if (fcnt_q == FCNT_W'(LOCK_FILTER - 1)) begin
                  state_d = HOLD;
                  hcnt_d  = '0;
               end
            end else begin
               fcnt_d = '0;
            end
         end
         HOLD: begin
            hcnt_d = hcnt_q + HCNT_W'(1);
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               fcnt_d  = '0;
               tcnt_d  = '0;
            end else if (hcnt_q == HCNT_W'(RST_HOLD - 1)) begin
               state_d        = RUN;
               lock_timeout_d = 1'b0;
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_d      = WAIT_LOCK;
               lost_pulse_d = 1'b1;
               fcnt_d       = '0;
               tcnt_d       = '0;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase

      sys_rst_d = (state_d != RUN);
      ready_d   = (state_d == RUN);
   end

   assign sys_rst      = sys_rst_q;
   assign ready        = ready_q;
   assign lost_pulse   = lost_pulse_q;
   assign lock_timeout = lock_timeout_q;

`ifdef LOCK_LOSS_CNT_EN
   logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

   always_comb begin
      loss_cnt_d = loss_cnt_q;
      if (lost_pulse_d && (loss_cnt_q != {CNT_W{1'b1}}))
         loss_cnt_d = loss_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) loss_cnt_q <= '0;
      else     loss_cnt_q <= loss_cnt_d;
   end

   assign loss_cnt = loss_cnt_q;
`else
   assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq with SYNC_STAGES=2, LOCK_FILTER=4, RST_HOLD=3, TIMEOUT=20, CNT_W=2.
module tb_pll_lock_reset_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       locked;
   logic       sys_rst;
   logic       ready;
   logic       lost_pulse;
   logic       lock_timeout;
   logic [1:0] loss_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   pll_lock_reset_seq #(
      .SYNC_STAGES(2),
      .LOCK_FILTER(4),
      .RST_HOLD   (3),
      .TIMEOUT    (20),
      .CNT_W      (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .locked      (locked),
      .sys_rst     (sys_rst),
      .ready       (ready),
      .lost_pulse  (lost_pulse),
      .lock_timeout(lock_timeout),
      .loss_cnt    (loss_cnt)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the last edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected loss_cnt for the k-th loss (saturates at 3 with CNT_W=2).
   function automatic logic [31:0] exp_cnt(input int k);
`ifdef LOCK_LOSS_CNT_EN
      return (k > 3) ? 32'd3 : 32'(k);
`else
      return 32'd0 + 32'(k - k);
`endif
   endfunction

   initial begin
      rst    = 1'b1;
      locked = 1'b0;
      #2;
      chk("rst_sys_rst", 32'(sys_rst), 32'd1);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_lost", 32'(lost_pulse), 32'd0);
      chk("rst_timeout", 32'(lock_timeout), 32'd0);
      chk("rst_loss_cnt", 32'(loss_cnt), 32'd0);
      step(2);
      rst = 1'b0;

      // Steady lock: sys_rst falls on edge 9.
      locked = 1'b1;
      step(8);
      chk("lock_e8_sys_rst", 32'(sys_rst), 32'd1);
      chk("lock_e8_ready", 32'(ready), 32'd0);
      step(1);
      chk("lock_e9_sys_rst", 32'(sys_rst), 32'd0);
      chk("lock_e9_ready", 32'(ready), 32'd1);
      chk("lock_e9_timeout", 32'(lock_timeout), 32'd0);

      // Loss in RUN: sys_rst and lost_pulse on the third low-sampling edge.
      locked = 1'b0;
      step(2);
      chk("loss1_e2_sys_rst", 32'(sys_rst), 32'd0);
      chk("loss1_e2_lost", 32'(lost_pulse), 32'd0);
      step(1);
      chk("loss1_e3_sys_rst", 32'(sys_rst), 32'd1);
      chk("loss1_e3_lost", 32'(lost_pulse), 32'd1);
      chk("loss1_e3_ready", 32'(ready), 32'd0);
      chk("loss1_cnt", 32'(loss_cnt), exp_cnt(1));
      step(1);
      chk("loss1_e4_lost", 32'(lost_pulse), 32'd0);
      chk("loss1_e4_sys_rst", 32'(sys_rst), 32'd1);

      // Glitch: high 3, low 1, high again; sys_rst falls 9 edges after the re-rise.
      locked = 1'b1;
      step(3);
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      step(8);
      chk("glitch_e8_sys_rst", 32'(sys_rst), 32'd1);
      step(1);
      chk("glitch_e9_sys_rst", 32'(sys_rst), 32'd0);
      chk("glitch_e9_ready", 32'(ready), 32'd1);

      // Second loss.
      locked = 1'b0;
      step(3);
      chk("loss2_lost", 32'(lost_pulse), 32'd1);
      chk("loss2_cnt", 32'(loss_cnt), exp_cnt(2));
      step(1);

      // Drop in the first HOLD cycle.
      locked = 1'b1;
      step(4);
      locked = 1'b0;
      step(3);
      chk("hold_early_sys_rst", 32'(sys_rst), 32'd1);
      chk("hold_early_lost", 32'(lost_pulse), 32'd0);
      step(3);
      chk("hold_early_later_sys_rst", 32'(sys_rst), 32'd1);
      chk("hold_early_later_ready", 32'(ready), 32'd0);

      // Drop in the final HOLD cycle: loss wins over RUN entry.
      locked = 1'b1;
      step(6);
      locked = 1'b0;
      step(2);
      chk("hold_final_e8_sys_rst", 32'(sys_rst), 32'd1);
      step(1);
      chk("hold_final_e9_sys_rst", 32'(sys_rst), 32'd1);
      chk("hold_final_e9_ready", 32'(ready), 32'd0);
      chk("hold_final_e9_lost", 32'(lost_pulse), 32'd0);
      chk("hold_final_cnt", 32'(loss_cnt), exp_cnt(2));

      // Timeout: tcnt restarted on the HOLD exit edge, flag sets 20 edges later.
      step(19);
      chk("timeout_e19", 32'(lock_timeout), 32'd0);
      step(1);
      chk("timeout_e20", 32'(lock_timeout), 32'd1);
      step(5);
      chk("timeout_sticky", 32'(lock_timeout), 32'd1);
      locked = 1'b1;
      step(8);
      chk("timeout_pre_run", 32'(lock_timeout), 32'd1);
      chk("timeout_pre_run_sys_rst", 32'(sys_rst), 32'd1);
      step(1);
      chk("timeout_run_clear", 32'(lock_timeout), 32'd0);
      chk("timeout_run_sys_rst", 32'(sys_rst), 32'd0);

      // Losses 3..5 exercise counter saturation.
      for (int k = 3; k <= 5; k++) begin
         locked = 1'b0;
         step(3);
         chk($sformatf("loss%0d_lost", k), 32'(lost_pulse), 32'd1);
         chk($sformatf("loss%0d_cnt", k), 32'(loss_cnt), exp_cnt(k));
         step(1);
         chk($sformatf("loss%0d_lost_off", k), 32'(lost_pulse), 32'd0);
         locked = 1'b1;
         step(9);
         chk($sformatf("relock%0d_ready", k), 32'(ready), 32'd1);
      end

      // Asynchronous reset while in RUN.
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_sys_rst", 32'(sys_rst), 32'd1);
      chk("async_rst_ready", 32'(ready), 32'd0);
      chk("async_rst_cnt", 32'(loss_cnt), 32'd0);
      chk("async_rst_lost", 32'(lost_pulse), 32'd0);
      step(2);
      chk("async_rst_hold_lost", 32'(lost_pulse), 32'd0);
      chk("async_rst_hold_sys_rst", 32'(sys_rst), 32'd1);
      rst = 1'b0;
      step(9);
      chk("post_rst_relock_sys_rst", 32'(sys_rst), 32'd0);
      chk("post_rst_cnt", 32'(loss_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
